// File: rtl/sys_cmd_pkg.sv
// sys_cmd_pkg: opcodes, operand addresses and FSM state type for sys_cmd_ctrl
package sys_cmd_pkg;
   localparam logic [7:0] CMD_WR      = 8'hAA;
   localparam logic [7:0] CMD_RD      = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
   localparam int OPA_ADDR = 0;
   localparam int OPB_ADDR = 1;
   typedef enum logic [3:0] {
      IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT, TX_LO, TX_HI
   } state_t;
endpackage

// File: rtl/sys_cmd_ctrl.sv
// sys_cmd_ctrl: decodes UART command bytes into register-file and ALU operations and returns responses over a byte handshake
module sys_cmd_ctrl
   import sys_cmd_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      rx_data_valid,
   input  logic [DATA_WIDTH-1:0]     rx_p_data,
   input  logic                      rx_par_err,
   input  logic                      rx_stp_err,
   output logic                      rf_wr_en,
   output logic                      rf_rd_en,
   output logic [ADDR_WIDTH-1:0]     rf_addr,
   output logic [DATA_WIDTH-1:0]     rf_wr_data,
   input  logic [DATA_WIDTH-1:0]     rf_rd_data,
   input  logic                      rf_rd_valid,
   output logic                      alu_en,
   output logic [3:0]                alu_fun,
   output logic                      clk_gate_en,
   input  logic [2*DATA_WIDTH-1:0]   alu_out,
   input  logic                      alu_out_valid,
   output logic                      tx_valid,
   output logic [DATA_WIDTH-1:0]     tx_data,
   input  logic                      tx_ready,
   output logic                      cmd_err,
   output logic [7:0]                err_cnt
);
   state_t state_q, state_d;
   logic rf_wr_en_q, rf_wr_en_d, rf_rd_en_q, rf_rd_en_d, alu_en_q, alu_en_d;
   logic clk_gate_en_q, clk_gate_en_d, tx_valid_q, tx_valid_d, cmd_err_q, cmd_err_d;
   logic two_q, two_d;
   logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
   logic [DATA_WIDTH-1:0] rf_wr_data_q, rf_wr_data_d, tx_data_q, tx_data_d, res_hi_q, res_hi_d;
   logic [3:0] alu_fun_q, alu_fun_d;
   logic [7:0] err_cnt_q, err_cnt_d;
   logic rx_ok, rx_bad, busy;

   assign rx_bad = rx_data_valid && (rx_par_err || rx_stp_err);
   assign rx_ok  = rx_data_valid && !rx_par_err && !rx_stp_err;
   assign busy   = state_q == RD_WAIT || state_q == ALU_WAIT || state_q == TX_LO || state_q == TX_HI;

   always_comb begin
      state_d      = state_q;
      rf_wr_en_d   = 1'b0;
      rf_rd_en_d   = 1'b0;
      alu_en_d     = 1'b0;
      cmd_err_d    = 1'b0;
      rf_addr_d    = rf_addr_q;
      rf_wr_data_d = rf_wr_data_q;
      alu_fun_d    = alu_fun_q;
      tx_valid_d   = tx_valid_q;
      tx_data_d    = tx_data_q;
      res_hi_d     = res_hi_q;
      two_d        = two_q;
      err_cnt_d    = err_cnt_q;
      case (state_q)
         IDLE: if (rx_ok) begin
            state_d   = rx_p_data == CMD_WR      ? WR_ADDR :
                        rx_p_data == CMD_RD      ? RD_ADDR :
                        rx_p_data == CMD_ALU_OP  ? OP_A    :
                        rx_p_data == CMD_ALU_NOP ? ALU_FUN : IDLE;
            cmd_err_d = state_d == IDLE;
         end
         WR_ADDR: if (rx_ok) begin
            rf_addr_d = rx_p_data[ADDR_WIDTH-1:0];
            state_d   = WR_DATA;
         end
         WR_DATA: if (rx_ok) begin
            rf_wr_data_d = rx_p_data;
            rf_wr_en_d   = 1'b1;
            state_d      = IDLE;
         end
         RD_ADDR: if (rx_ok) begin
            rf_addr_d  = rx_p_data[ADDR_WIDTH-1:0];
            rf_rd_en_d = 1'b1;
            state_d    = RD_WAIT;
         end
         RD_WAIT: if (rf_rd_valid) begin
            tx_data_d  = rf_rd_data;
            tx_valid_d = 1'b1;
            two_d      = 1'b0;
            state_d    = TX_LO;
         end
         OP_A: if (rx_ok) begin
            rf_addr_d    = ADDR_WIDTH'(OPA_ADDR);
            rf_wr_data_d = rx_p_data;
            rf_wr_en_d   = 1'b1;
            state_d      = OP_B;
         end
         OP_B: if (rx_ok) begin
            rf_addr_d    = ADDR_WIDTH'(OPB_ADDR);
            rf_wr_data_d = rx_p_data;
            rf_wr_en_d   = 1'b1;
            state_d      = ALU_FUN;
         end
         ALU_FUN: if (rx_ok) begin
            alu_fun_d = rx_p_data[3:0];
            alu_en_d  = 1'b1;
            state_d   = ALU_WAIT;
         end
         ALU_WAIT: if (alu_out_valid) begin
            tx_data_d  = alu_out[DATA_WIDTH-1:0];
            res_hi_d   = alu_out[2*DATA_WIDTH-1:DATA_WIDTH];
            tx_valid_d = 1'b1;
            two_d      = 1'b1;
            state_d    = TX_LO;
         end
         TX_LO: if (tx_ready) begin
            tx_data_d  = two_q ? res_hi_q : tx_data_q;
            tx_valid_d = two_q;
            state_d    = two_q ? TX_HI : IDLE;
         end
         TX_HI: if (tx_ready) begin
            tx_valid_d = 1'b0;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // a corrupted byte aborts whatever is in flight, including a pending response
      if (rx_bad) begin
         state_d    = IDLE;
         tx_valid_d = 1'b0;
         cmd_err_d  = 1'b1;
         err_cnt_d  = err_cnt_q == 8'hFF ? err_cnt_q : err_cnt_q + 8'd1;
      end else if (rx_data_valid && busy) begin
         cmd_err_d = 1'b1;
      end
      clk_gate_en_d = state_d == ALU_FUN || state_d == ALU_WAIT;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q       <= IDLE;
         rf_wr_en_q    <= 1'b0;
         rf_rd_en_q    <= 1'b0;
         alu_en_q      <= 1'b0;
         clk_gate_en_q <= 1'b0;
         tx_valid_q    <= 1'b0;
         cmd_err_q     <= 1'b0;
         two_q         <= 1'b0;
         rf_addr_q     <= '0;
         rf_wr_data_q  <= '0;
         tx_data_q     <= '0;
         res_hi_q      <= '0;
         alu_fun_q     <= '0;
         err_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         rf_wr_en_q    <= rf_wr_en_d;
         rf_rd_en_q    <= rf_rd_en_d;
         alu_en_q      <= alu_en_d;
         clk_gate_en_q <= clk_gate_en_d;
         tx_valid_q    <= tx_valid_d;
         cmd_err_q     <= cmd_err_d;
         two_q         <= two_d;
         rf_addr_q     <= rf_addr_d;
         rf_wr_data_q  <= rf_wr_data_d;
         tx_data_q     <= tx_data_d;
         res_hi_q      <= res_hi_d;
         alu_fun_q     <= alu_fun_d;
         err_cnt_q     <= err_cnt_d;
      end
   end

   assign rf_wr_en    = rf_wr_en_q;
   assign rf_rd_en    = rf_rd_en_q;
   assign rf_addr     = rf_addr_q;
   assign rf_wr_data  = rf_wr_data_q;
   assign alu_en      = alu_en_q;
   assign alu_fun     = alu_fun_q;
   assign clk_gate_en = clk_gate_en_q;
   assign tx_valid    = tx_valid_q;
   assign tx_data     = tx_data_q;
   assign cmd_err     = cmd_err_q;
   assign err_cnt     = err_cnt_q;
endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// tb_sys_cmd_ctrl: directed and random command streams checked against a transaction-level event model
module tb_sys_cmd_ctrl;
   logic CLK = 1'b0, RST = 1'b1;
   logic rx_data_valid = 1'b0, rx_par_err = 1'b0, rx_stp_err = 1'b0;
   logic [7:0] rx_p_data = '0;
   logic rf_wr_en, rf_rd_en, alu_en, clk_gate_en, tx_valid, cmd_err;
   logic [3:0] rf_addr, alu_fun;
   logic [7:0] rf_wr_data, tx_data, err_cnt;
   logic [7:0] rf_rd_data = '0;
   logic rf_rd_valid = 1'b0, alu_out_valid = 1'b0, tx_ready = 1'b0;
   logic [15:0] alu_out = '0;

   sys_cmd_ctrl dut (
      .CLK(CLK), .RST(RST), .rx_data_valid(rx_data_valid), .rx_p_data(rx_p_data),
      .rx_par_err(rx_par_err), .rx_stp_err(rx_stp_err), .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en),
      .rf_addr(rf_addr), .rf_wr_data(rf_wr_data), .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid),
      .alu_en(alu_en), .alu_fun(alu_fun), .clk_gate_en(clk_gate_en), .alu_out(alu_out),
      .alu_out_valid(alu_out_valid), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .cmd_err(cmd_err), .err_cnt(err_cnt)
   );

   always #5 CLK = ~CLK;

   int checks = 0, failures = 0;
   logic [31:0] exp_q[$], obs_q[$];
   logic [7:0] mem_m [16];
   logic [7:0] err_m = 8'd0;
   int rd_lat = 2, alu_lat = 3;
   logic [15:0] alu_val = 16'h0;
   bit rdy_lo = 1'b0;
   logic pv = 1'b0, pr = 1'b0;
   logic [7:0] pd = '0;

   localparam logic [7:0] EV_W = 8'd1, EV_R = 8'd2, EV_A = 8'd3, EV_T = 8'd4, EV_E = 8'd5;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ev(input logic [7:0] t, input logic [7:0] a, input logic [7:0] d);
      return {8'h00, t, a, d};
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic pe, input logic se);
      rx_p_data = b; rx_par_err = pe; rx_stp_err = se; rx_data_valid = 1'b1;
      tick();
      rx_data_valid = 1'b0; rx_par_err = 1'b0; rx_stp_err = 1'b0;
   endtask

   task automatic exp_wr(input logic [7:0] a, input logic [7:0] d);
      exp_q.push_back(ev(EV_W, a & 8'h0F, d));
      mem_m[a[3:0]] = d;
   endtask

   task automatic exp_rd(input logic [7:0] a);
      exp_q.push_back(ev(EV_R, a & 8'h0F, 8'h00));
      exp_q.push_back(ev(EV_T, 8'h00, mem_m[a[3:0]]));
   endtask

   task automatic exp_alu(input logic [7:0] f);
      exp_q.push_back(ev(EV_A, f & 8'h0F, 8'h00));
      exp_q.push_back(ev(EV_T, 8'h00, alu_val[7:0]));
      exp_q.push_back(ev(EV_T, 8'h00, alu_val[15:8]));
   endtask

   task automatic exp_frame();
      exp_q.push_back(ev(EV_E, 8'h00, 8'h00));
      err_m = (err_m == 8'hFF) ? err_m : err_m + 8'd1;
   endtask

   task automatic finish_cmd(input string tag);
      int n = 0;
      while (obs_q.size() < exp_q.size() && n < 400) begin
         tick();
         n++;
      end
      repeat (3) tick();
      chk({tag, "_nevents"}, obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) chk({tag, "_event"}, obs_q[i], exp_q[i]);
      chk({tag, "_err_cnt"}, {24'h0, err_cnt}, {24'h0, err_m});
      obs_q.delete();
      exp_q.delete();
   endtask

   // transaction monitor: turns DUT strobes and handshakes into events
   always @(negedge CLK) begin
      if (!RST) begin
         if (rf_wr_en) obs_q.push_back(ev(EV_W, {4'h0, rf_addr}, rf_wr_data));
         if (rf_rd_en) obs_q.push_back(ev(EV_R, {4'h0, rf_addr}, 8'h00));
         if (alu_en) begin
            obs_q.push_back(ev(EV_A, {4'h0, alu_fun}, 8'h00));
            chk("gate_at_alu_en", {31'h0, clk_gate_en}, 32'd1);
         end
         if (tx_valid && tx_ready) obs_q.push_back(ev(EV_T, 8'h00, tx_data));
         if (cmd_err) obs_q.push_back(ev(EV_E, 8'h00, 8'h00));
         if (pv && !pr) begin
            chk("tx_hold_valid", {31'h0, tx_valid}, 32'd1);
            chk("tx_hold_data", {24'h0, tx_data}, {24'h0, pd});
         end
         pv <= tx_valid; pr <= tx_ready; pd <= tx_data;
      end else begin
         pv <= 1'b0;
      end
   end

   initial begin : rd_resp
      logic [3:0] a;
      forever begin
         @(negedge CLK);
         if (rf_rd_en && !RST) begin
            a = rf_addr;
            repeat (rd_lat) @(posedge CLK);
            #1 rf_rd_valid = 1'b1; rf_rd_data = mem_m[a];
            @(posedge CLK);
            #1 rf_rd_valid = 1'b0; rf_rd_data = 8'($urandom);
         end
      end
   end

   initial begin : alu_resp
      forever begin
         @(negedge CLK);
         if (alu_en && !RST) begin
            repeat (alu_lat) @(posedge CLK);
            #1 alu_out_valid = 1'b1; alu_out = alu_val;
            @(posedge CLK);
            #1 alu_out_valid = 1'b0;
         end
      end
   end

   initial begin : tx_sink
      forever begin
         @(posedge CLK);
         #1 tx_ready = rdy_lo ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   task automatic run_cmd(input int kind);
      logic [7:0] b[4];
      int len, ab;
      alu_val = 16'($urandom);
      rd_lat  = $urandom_range(1, 4);
      alu_lat = $urandom_range(1, 4);
      for (int j = 1; j < 4; j++) b[j] = 8'($urandom);
      b[0] = kind == 0 ? 8'hAA : kind == 1 ? 8'hBB : kind == 2 ? 8'hCC : 8'hDD;
      if (kind == 4) begin
         b[0] = 8'($urandom);
         while (b[0] == 8'hAA || b[0] == 8'hBB || b[0] == 8'hCC || b[0] == 8'hDD) b[0] = 8'($urandom);
      end
      len = kind == 0 ? 3 : kind == 1 ? 2 : kind == 2 ? 4 : kind == 3 ? 2 : 1;
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : -1;
      for (int j = 0; j < len; j++) begin
         if (j == ab) begin
            logic pe;
            pe = 1'($urandom_range(0, 1));
            send_byte(8'($urandom), pe, !pe || 1'($urandom_range(0, 1)));
            exp_frame();
            break;
         end
         send_byte(b[j], 1'b0, 1'b0);
         case (kind)
            0: if (j == 2) exp_wr(b[1], b[2]);
            1: if (j == 1) exp_rd(b[1]);
            2: begin
               if (j == 1) exp_wr(8'd0, b[1]);
               if (j == 2) exp_wr(8'd1, b[2]);
               if (j == 3) exp_alu(b[3]);
            end
            3: if (j == 1) exp_alu(b[1]);
            default: exp_q.push_back(ev(EV_E, 8'h00, 8'h00));
         endcase
         if (j < len - 1) repeat ($urandom_range(0, 2)) tick();
      end
      finish_cmd("rand");
   endtask

   initial begin : watchdog
      #2000000;
      failures++;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
      repeat (3) tick();
      chk("rst_wr_en", {31'h0, rf_wr_en}, 32'd0);
      chk("rst_tx_valid", {31'h0, tx_valid}, 32'd0);
      chk("rst_gate", {31'h0, clk_gate_en}, 32'd0);
      chk("rst_err_cnt", {24'h0, err_cnt}, 32'd0);
      chk("rst_tx_data", {24'h0, tx_data}, 32'd0);
      RST = 1'b0;
      tick();

      send_byte(8'hAA, 0, 0); send_byte(8'h05, 0, 0);
      chk("wr_early", {31'h0, rf_wr_en}, 32'd0);
      send_byte(8'h3C, 0, 0);
      exp_wr(8'h05, 8'h3C);
      chk("wr_en", {31'h0, rf_wr_en}, 32'd1);
      chk("wr_addr", {28'h0, rf_addr}, 32'h5);
      chk("wr_data", {24'h0, rf_wr_data}, 32'h3C);
      tick();
      chk("wr_pulse_end", {31'h0, rf_wr_en}, 32'd0);
      chk("wr_no_tx", {31'h0, tx_valid}, 32'd0);
      finish_cmd("wr");

      rdy_lo = 1'b1; rd_lat = 2;
      send_byte(8'hBB, 0, 0); send_byte(8'h05, 0, 0);
      exp_rd(8'h05);
      chk("rd_en", {31'h0, rf_rd_en}, 32'd1);
      chk("rd_addr", {28'h0, rf_addr}, 32'h5);
      tick();
      chk("rd_pulse_end", {31'h0, rf_rd_en}, 32'd0);
      tick();
      chk("rd_tx_early", {31'h0, tx_valid}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rd_tx_valid", {31'h0, tx_valid}, 32'd1);
         chk("rd_tx_data", {24'h0, tx_data}, 32'h3C);
      end
      rdy_lo = 1'b0;
      finish_cmd("rd");

      alu_val = 16'h0015; alu_lat = 3;
      send_byte(8'hCC, 0, 0); send_byte(8'h07, 0, 0);
      exp_wr(8'h00, 8'h07);
      chk("opa_addr", {28'h0, rf_addr}, 32'h0);
      chk("opa_data", {24'h0, rf_wr_data}, 32'h07);
      chk("opa_gate", {31'h0, clk_gate_en}, 32'd0);
      send_byte(8'h03, 0, 0);
      exp_wr(8'h01, 8'h03);
      chk("opb_addr", {28'h0, rf_addr}, 32'h1);
      chk("fun_gate", {31'h0, clk_gate_en}, 32'd1);
      send_byte(8'h02, 0, 0);
      exp_alu(8'h02);
      chk("alu_en", {31'h0, alu_en}, 32'd1);
      chk("alu_fun", {28'h0, alu_fun}, 32'h2);
      tick(); tick();
      chk("alu_wait_gate", {31'h0, clk_gate_en}, 32'd1);
      chk("alu_wait_tx", {31'h0, tx_valid}, 32'd0);
      tick();
      chk("alu_valid_gate", {31'h0, clk_gate_en}, 32'd1);
      tick();
      chk("alu_gate_off", {31'h0, clk_gate_en}, 32'd0);
      chk("alu_tx_valid", {31'h0, tx_valid}, 32'd1);
      chk("alu_tx_lo", {24'h0, tx_data}, 32'h15);
      finish_cmd("alu");

      send_byte(8'hAA, 0, 0); send_byte(8'h05, 0, 0); send_byte(8'h3C, 1, 0);
      exp_frame();
      chk("frame_cmd_err", {31'h0, cmd_err}, 32'd1);
      chk("frame_no_wr", {31'h0, rf_wr_en}, 32'd0);
      chk("frame_err_cnt", {24'h0, err_cnt}, 32'd1);
      finish_cmd("frame");
      for (int i = 0; i < 256; i++) begin
         send_byte(8'($urandom), i[0], !i[0]);
         exp_frame();
      end
      finish_cmd("sat");

      send_byte(8'h42, 0, 0);
      exp_q.push_back(ev(EV_E, 8'h00, 8'h00));
      chk("badop_cmd_err", {31'h0, cmd_err}, 32'd1);
      send_byte(8'hAA, 0, 0); send_byte(8'h0A, 0, 0); send_byte(8'h5A, 0, 0);
      exp_wr(8'h0A, 8'h5A);
      finish_cmd("badop");

      rd_lat = 4;
      send_byte(8'hBB, 0, 0); send_byte(8'h05, 0, 0);
      exp_q.push_back(ev(EV_R, 8'h05, 8'h00));
      send_byte(8'h11, 0, 0);
      exp_q.push_back(ev(EV_E, 8'h00, 8'h00));
      exp_q.push_back(ev(EV_T, 8'h00, mem_m[5]));
      chk("ovr_cmd_err", {31'h0, cmd_err}, 32'd1);
      finish_cmd("ovr");

      alu_lat = 4;
      send_byte(8'hCC, 0, 0); send_byte(8'h11, 0, 0); send_byte(8'h22, 0, 0); send_byte(8'h03, 0, 0);
      mem_m[0] = 8'h11; mem_m[1] = 8'h22;
      tick();
      RST = 1'b1;
      tick();
      chk("mrst_wr_en", {31'h0, rf_wr_en}, 32'd0);
      chk("mrst_rd_en", {31'h0, rf_rd_en}, 32'd0);
      chk("mrst_alu_en", {31'h0, alu_en}, 32'd0);
      chk("mrst_addr", {28'h0, rf_addr}, 32'd0);
      chk("mrst_wr_data", {24'h0, rf_wr_data}, 32'd0);
      chk("mrst_alu_fun", {28'h0, alu_fun}, 32'd0);
      chk("mrst_gate", {31'h0, clk_gate_en}, 32'd0);
      chk("mrst_tx_valid", {31'h0, tx_valid}, 32'd0);
      chk("mrst_tx_data", {24'h0, tx_data}, 32'd0);
      chk("mrst_cmd_err", {31'h0, cmd_err}, 32'd0);
      chk("mrst_err_cnt", {24'h0, err_cnt}, 32'd0);
      RST = 1'b0;
      err_m = 8'd0;
      obs_q.delete(); exp_q.delete();
      repeat (8) tick();
      send_byte(8'hAA, 0, 0); send_byte(8'h01, 0, 0); send_byte(8'hFF, 0, 0);
      exp_wr(8'h01, 8'hFF);
      finish_cmd("post_rst");

      repeat (200) run_cmd($urandom_range(0, 4));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sys_cmd_ctrl.md
# sys_cmd_ctrl

Command controller that sits downstream of the UART receiver and sequences the shared register file, the ALU and the UART transmitter. It consumes received bytes (data plus parity/stop error flags), decodes a 4-command protocol and issues register writes, register reads and ALU operations. It gates the ALU clock and returns read data or ALU results to the transmitter through a valid/ready byte handshake. It also discards corrupted frames and counts them.

## Interface
- `DATA_WIDTH`, 8: byte width for RX, TX and the register file.
- `ADDR_WIDTH`, 4: register-file address width.
- `CLK` in 1: system clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `rx_data_valid` in 1: one-cycle pulse, received byte available.
- `rx_p_data` in DATA_WIDTH: received byte, valid with `rx_data_valid`.
- `rx_par_err`, `rx_stp_err` in 1: error flags for the current byte, sampled with `rx_data_valid`.
- `rf_wr_en`, `rf_rd_en` out 1: register-file strobes, one-cycle pulses.
- `rf_addr` out ADDR_WIDTH: register address.
- `rf_wr_data` out DATA_WIDTH: write data.
- `rf_rd_data` in DATA_WIDTH: read data, valid with `rf_rd_valid`.
- `rf_rd_valid` in 1: read data strobe.
- `alu_en` out 1: one-cycle ALU start pulse.
- `alu_fun` out 4: ALU function code.
- `clk_gate_en` out 1: ALU clock-gate enable.
- `alu_out` in 2*DATA_WIDTH: ALU result.
- `alu_out_valid` in 1: result strobe.
- `tx_valid` out 1: byte offered to the transmitter.
- `tx_data` out DATA_WIDTH: byte offered.
- `tx_ready` in 1: transmitter accepts; a byte transfers on `tx_valid && tx_ready`.
- `cmd_err` out 1: one-cycle pulse on a dropped frame, unknown opcode or overrun.
- `err_cnt` out 8: saturating count of frames with parity or stop error.

## Operation
- Opcodes:
  - `0xAA`: write. Next two bytes are address, then data.
  - `0xBB`: read. Next byte is address.
  - `0xCC`: ALU with operands. Next bytes are A, B, FUN.
  - `0xDD`: ALU without operands. Next byte is FUN.
- Address bytes use the low ADDR_WIDTH bits; upper bits are ignored. FUN bytes use the low 4 bits.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT, TX_LO, TX_HI.
- IDLE:
  - `0xAA` → WR_ADDR; `0xBB` → RD_ADDR; `0xCC` → OP_A; `0xDD` → ALU_FUN.
  - Any other value pulses `cmd_err` and stays in IDLE.
- WR_ADDR: latch address → WR_DATA.
- WR_DATA: `rf_wr_en` pulses with latched address and data → IDLE.
- RD_ADDR: `rf_rd_en` pulses → RD_WAIT.
- RD_WAIT: on `rf_rd_valid`, capture `rf_rd_data` into the TX low byte → TX_LO, single-byte response.
- OP_A: write operand to address 0 → OP_B.
- OP_B: write operand to address 1 → ALU_FUN.
- ALU_FUN: latch `alu_fun`, pulse `alu_en` → ALU_WAIT.
- ALU_WAIT: on `alu_out_valid`, capture `alu_out` → TX_LO, two-byte response.
- TX_LO: `tx_valid` high with the low byte until `tx_ready`. Then → TX_HI for a two-byte response, else → IDLE.
- TX_HI: high byte, same rule → IDLE.
- Frame error: `rx_data_valid` with `rx_par_err` or `rx_stp_err` in any state drops the byte, pulses `cmd_err`, increments `err_cnt` (saturates at 255) and aborts to IDLE. An aborted command performs no register write.
- Overrun: `rx_data_valid` in RD_WAIT, ALU_WAIT, TX_LO or TX_HI drops the byte and pulses `cmd_err`; the state is unchanged.
- Stray inputs: `rf_rd_valid` outside RD_WAIT and `alu_out_valid` outside ALU_WAIT are ignored.
- `clk_gate_en`: high from entry into ALU_FUN until the cycle `alu_out_valid` is captured, inclusive.

## Timing
- All outputs are registered.
- Reset values:
  - All strobes, `tx_valid`, `cmd_err` and `clk_gate_en` are 0.
  - `rf_addr`, `rf_wr_data`, `alu_fun` and `tx_data` are 0; `err_cnt` is 0.
  - State is IDLE.
- `RST` mid-command: every output returns to its reset value on the next edge, and the in-flight command is lost.
- `rf_wr_en`, `rf_rd_en` and `alu_en` assert the cycle after the accepting `rx_data_valid`, for exactly 1 cycle.
- `tx_valid` asserts the cycle after `rf_rd_valid`/`alu_out_valid` is captured. `tx_data` is stable while `tx_valid` is high.
- Back-to-back bytes: `tx_valid` of the high byte asserts the cycle after the low-byte handshake.
- First acceptance: a new command byte is accepted in IDLE the cycle after the final TX handshake or write pulse.
- `cmd_err` asserts the cycle after the offending `rx_data_valid`.

## Structure
- Shared package `sys_cmd_pkg` holds:
  - opcode constants `CMD_WR`, `CMD_RD`, `CMD_ALU_OP`, `CMD_ALU_NOP`;
  - operand addresses `OPA_ADDR = 0`, `OPB_ADDR = 1`;
  - the FSM state typedef.
- Single module with one FSM; no sub-module required. The saturating error counter is inline.

## Test plan
- Write command: bytes AA,05,3C → one-cycle `rf_wr_en` with `rf_addr=5`, `rf_wr_data=0x3C`; no `tx_valid`.
- Read command: bytes BB,05; model returns 0x3C two cycles after `rf_rd_en` → `tx_valid` with 0x3C held through 3 `tx_ready`-low cycles; single transfer; back to IDLE.
- ALU with operands: bytes CC,07,03,02; `alu_out=0x0015` → writes 07@0 and 03@1, `alu_en` with `alu_fun=2`, `clk_gate_en` high until result, TX sends 0x15 then 0x00.
- Frame error: AA,05 then a data byte with `rx_par_err=1` → no `rf_wr_en`, `cmd_err` pulse, `err_cnt=1`. Then 256 such bytes → `err_cnt` holds 255.
- Bad opcode and overrun: byte 0x42 in IDLE → `cmd_err`, stays IDLE. Byte received during RD_WAIT → `cmd_err`, read completes normally.
- Reset mid-op: `RST` asserted in ALU_WAIT → all outputs 0 next edge; AA,01,FF afterwards writes normally.
